// File: rtl/dmem_bus_fabric.sv
// Data-memory interconnect: cpu dmem port to N address-decoded slaves,
// with ready handshake, per-access timeout and a sticky bus-error log.
module dmem_bus_fabric #(
    parameter int                     N_SLAVES      = 4,
    parameter logic [32*N_SLAVES-1:0] SLAVE_BASE    = '0,
    parameter logic [32*N_SLAVES-1:0] SLAVE_MASK    = '0,
    parameter int                     TIMEOUT       = 15,
    parameter logic [31:0]            UNMAPPED_DATA = 32'hfefefefe,
    parameter logic [31:0]            TIMEOUT_DATA  = 32'hfdfdfdfd
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              m_writeb,
    input  logic                    m_read,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    output logic [31:0]             m_rdata,
    output logic                    m_ready,
    output logic [N_SLAVES-1:0]     s_sel,
    output logic [4*N_SLAVES-1:0]   s_writeb,
    output logic [N_SLAVES-1:0]     s_read,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    input  logic [32*N_SLAVES-1:0]  s_rdata,
    input  logic [N_SLAVES-1:0]     s_ready,
    output logic                    err_valid,
    output logic [1:0]              err_cause,
    output logic [31:0]             err_addr,
    input  logic                    err_clr
);

    localparam int          IW       = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      writeb_q, writeb_d;
    logic            read_q, read_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_valid_q, err_valid_d;
    logic [1:0]      err_cause_q, err_cause_d;
    logic [31:0]     err_addr_q, err_addr_d;

    logic            req, is_wr, hit;
    logic [IW-1:0]   hit_idx;
    logic            sel_ready;
    logic [31:0]     sel_rdata;
    logic            err_evt;
    logic [1:0]      err_cause_new;
    logic [31:0]     err_addr_new;

    assign is_wr = |m_writeb;
    assign req   = m_read | is_wr;

    // Scan high to low so the lowest matching slot is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Strobes are decoded from state, so an async reset cuts them at once.
    always_comb begin
        s_sel     = '0;
        s_read    = '0;
        s_writeb  = '0;
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (IW'(i) == idx_q) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
                if (state_q == WAIT) begin
                    s_sel[i]          = 1'b1;
                    s_read[i]         = read_q;
                    s_writeb[4*i +: 4] = writeb_q;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        writeb_d      = writeb_q;
        read_d        = read_q;
        rdata_d       = rdata_q;
        err_evt       = 1'b0;
        err_cause_new = 2'b00;
        err_addr_new  = '0;
        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    addr_d   = m_addr;
                    wdata_d  = m_wdata;
                    writeb_d = m_writeb;
                    read_d   = m_read & ~is_wr;
                    idx_d    = hit_idx;
                    cnt_d    = '0;
                    state_d  = WAIT;
                end else if (req) begin
                    rdata_d       = (m_read & ~is_wr) ? UNMAPPED_DATA : '0;
                    err_evt       = 1'b1;
                    err_cause_new = 2'b01;
                    err_addr_new  = m_addr;
                    state_d       = RESP;
                end
            end
            WAIT: begin
                if (sel_ready) begin
                    rdata_d = read_q ? sel_rdata : '0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d       = read_q ? TIMEOUT_DATA : '0;
                    err_evt       = 1'b1;
                    err_cause_new = 2'b10;
                    err_addr_new  = addr_q;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A new error in the same cycle as a clear is kept.
    always_comb begin
        err_valid_d = err_valid_q;
        err_cause_d = err_cause_q;
        err_addr_d  = err_addr_q;
        if (err_clr) begin
            err_valid_d = 1'b0;
            err_cause_d = 2'b00;
            err_addr_d  = '0;
        end
        if (err_evt && (!err_valid_q || err_clr)) begin
            err_valid_d = 1'b1;
            err_cause_d = err_cause_new;
            err_addr_d  = err_addr_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            writeb_q    <= '0;
            read_q      <= 1'b0;
            rdata_q     <= '0;
            err_valid_q <= 1'b0;
            err_cause_q <= 2'b00;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            writeb_q    <= writeb_d;
            read_q      <= read_d;
            rdata_q     <= rdata_d;
            err_valid_q <= err_valid_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign m_ready   = (state_q == RESP);
    assign m_rdata   = rdata_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign err_valid = err_valid_q;
    assign err_cause = err_cause_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_dmem_bus_fabric.sv
// Randomized bench for dmem_bus_fabric: behavioural slaves on the bus side
// and an access-level reference model for latency, data, strobes and error log.
module tb_dmem_bus_fabric;

    localparam logic [127:0] BASE = {32'h40000000, 32'h00000000,
                                     32'hffff0700, 32'h00000000};
    localparam logic [127:0] MASK = {32'hf0000000, 32'hfff00000,
                                     32'hffffff00, 32'hffff0000};
    localparam logic [31:0] UNM = 32'hfefefefe;
    localparam logic [31:0] TOD = 32'hfdfdfdfd;

    logic         clk, rst_n;
    logic [3:0]   m_writeb;
    logic         m_read;
    logic [31:0]  m_addr, m_wdata, m_rdata;
    logic         m_ready;
    logic [3:0]   s_sel, s_read, s_ready;
    logic [15:0]  s_writeb;
    logic [31:0]  s_addr, s_wdata;
    logic [127:0] s_rdata;
    logic         err_valid, err_clr;
    logic [1:0]   err_cause;
    logic [31:0]  err_addr;

    dmem_bus_fabric #(
        .N_SLAVES(4), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
        .TIMEOUT(15), .UNMAPPED_DATA(UNM), .TIMEOUT_DATA(TOD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_writeb(m_writeb), .m_read(m_read), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
        .s_sel(s_sel), .s_writeb(s_writeb), .s_read(s_read),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_ready(s_ready), .err_valid(err_valid), .err_cause(err_cause),
        .err_addr(err_addr), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] dflt(input int sl, input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9e3779b1) ^ 32'(sl);
    endfunction

    function automatic logic [31:0] mkey(input int sl, input logic [31:0] a);
        return {sl[1:0], a[31:2]};
    endfunction

    // ---------------- behavioural slaves ----------------
    logic [31:0] smem [logic [31:0]];
    int k1 = 0;
    int wcnt = 0;

    assign s_ready = {1'b0, 1'b1, (s_sel[1] && (wcnt == k1 + 1)), 1'b1};

    always @(posedge clk) begin
        #1;
        wcnt = s_sel[1] ? wcnt + 1 : 0;
    end

    always @(negedge clk) begin
        logic [31:0] cur, kk;
        for (int i = 0; i < 3; i++) begin
            if (s_sel[i] && s_ready[i]) begin
                kk  = mkey(i, s_addr);
                cur = smem.exists(kk) ? smem[kk] : dflt(i, s_addr);
                for (int b = 0; b < 4; b++)
                    if (s_writeb[4*i+b]) cur[8*b +: 8] = s_wdata[8*b +: 8];
                smem[kk] = cur;
            end
        end
        for (int i = 0; i < 4; i++) begin
            kk = mkey(i, s_addr);
            s_rdata[32*i +: 32] = smem.exists(kk) ? smem[kk] : dflt(i, s_addr);
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_base [4] = '{32'h00000000, 32'hffff0700,
                                  32'h00000000, 32'h40000000};
    logic [31:0] ref_mask [4] = '{32'hffff0000, 32'hffffff00,
                                  32'hfff00000, 32'hf0000000};
    logic [31:0] ref_mem [logic [31:0]];
    logic        rv = 1'b0;
    logic [1:0]  rc = 2'b00;
    logic [31:0] ra = '0;

    function automatic int ref_slot(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & ref_mask[i]) == ref_base[i]) return i;
        return -1;
    endfunction

    task automatic access(input logic [31:0] a, input logic rd,
                          input logic [3:0] wb, input logic [31:0] wd,
                          input logic clr, input int k);
        int sl, lat_exp, lat, good, bad;
        logic is_wr, err, done;
        logic [1:0] cause;
        logic [31:0] exp_rd, cur, kk;
        logic [3:0] exp_sel, exp_rdv;
        logic [15:0] exp_wb;
        is_wr = |wb;
        if (!is_wr) rd = 1'b1;
        sl = ref_slot(a);
        err = 1'b0;
        cause = 2'b00;
        exp_sel = '0;
        exp_rdv = '0;
        exp_wb = '0;
        if (sl < 0) begin
            lat_exp = 1;
            exp_rd = is_wr ? 32'h0 : UNM;
            err = 1'b1;
            cause = 2'b01;
        end else if (sl == 3) begin
            lat_exp = 16;
            exp_rd = is_wr ? 32'h0 : TOD;
            err = 1'b1;
            cause = 2'b10;
        end else begin
            lat_exp = 2 + ((sl == 1) ? k : 0);
            kk = mkey(sl, a);
            cur = ref_mem.exists(kk) ? ref_mem[kk] : dflt(sl, a);
            for (int b = 0; b < 4; b++)
                if (wb[b]) cur[8*b +: 8] = wd[8*b +: 8];
            if (is_wr) ref_mem[kk] = cur;
            exp_rd = is_wr ? 32'h0 : cur;
        end
        if (sl >= 0) begin
            exp_sel = 4'(1 << sl);
            exp_wb = 16'(wb) << (4 * sl);
            if (!is_wr) exp_rdv = exp_sel;
        end
        if (clr) begin
            rv = 1'b0; rc = 2'b00; ra = '0;
        end
        if (err && !rv) begin
            rv = 1'b1; rc = cause; ra = a;
        end

        @(negedge clk);
        k1 = k;
        m_addr = a;
        m_read = rd;
        m_writeb = wb;
        m_wdata = wd;
        err_clr = clr;
        lat = 0; good = 0; bad = 0; done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            err_clr = 1'b0;
            lat++;
            if (m_ready) begin
                done = 1'b1;
                if ((|s_sel) || (|s_read) || (|s_writeb)) bad++;
            end else if (s_sel == exp_sel && s_writeb == exp_wb &&
                         s_read == exp_rdv) good++;
            else bad++;
        end
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("rdata", m_rdata, exp_rd);
        chk("strobe_cycles", 32'(good), 32'(lat_exp - 1));
        chk("stray_strobes", 32'(bad), 32'd0);
        chk("err_valid", 32'(err_valid), 32'(rv));
        chk("err_cause", 32'(err_cause), 32'(rc));
        chk("err_addr", err_addr, ra);
        @(negedge clk);
        m_read = 1'b0;
        m_writeb = '0;
        @(posedge clk);
        #1;
        chk("ready_single", 32'(m_ready), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sel"}, 32'(s_sel), 32'd0);
        chk({tag, "_read"}, 32'(s_read), 32'd0);
        chk({tag, "_writeb"}, 32'(s_writeb), 32'd0);
        chk({tag, "_ready"}, 32'(m_ready), 32'd0);
        chk({tag, "_rdata"}, m_rdata, 32'd0);
        chk({tag, "_saddr"}, s_addr, 32'd0);
        chk({tag, "_swdata"}, s_wdata, 32'd0);
        chk({tag, "_errv"}, 32'(err_valid), 32'd0);
        chk({tag, "_errc"}, 32'(err_cause), 32'd0);
        chk({tag, "_erra"}, err_addr, 32'd0);
    endtask

    initial begin
        int stale;
        logic [31:0] a;
        logic [3:0] wb;
        int cat;
        rst_n = 1'b0;
        m_read = 1'b0;
        m_writeb = '0;
        m_addr = '0;
        m_wdata = '0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        access(32'h00000010, 1'b1, 4'b0000, 32'h0, 1'b0, 0);
        access(32'hffff0704, 1'b0, 4'b0001, 32'h000000a5, 1'b0, 3);
        access(32'hffff0704, 1'b1, 4'b0000, 32'h0, 1'b0, 0);
        access(32'h80000000, 1'b1, 4'b0000, 32'h0, 1'b0, 0);
        access(32'h40000010, 1'b1, 4'b0000, 32'h0, 1'b1, 0);
        access(32'h90000000, 1'b1, 4'b0000, 32'h0, 1'b0, 0);
        access(32'h00000020, 1'b1, 4'b0000, 32'h0, 1'b1, 0);
        access(32'h00000004, 1'b1, 4'b1111, 32'hcafef00d, 1'b0, 0);
        access(32'h00010008, 1'b1, 4'b0000, 32'h0, 1'b0, 0);
        access(32'ha0000000, 1'b0, 4'b0110, 32'h11223344, 1'b0, 0);
        access(32'hb0000000, 1'b1, 4'b0000, 32'h0, 1'b1, 0);

        // reset in the middle of a waiting read on slot 1
        @(negedge clk);
        k1 = 10;
        m_addr = 32'hffff0710;
        m_read = 1'b1;
        m_writeb = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_read", 32'(s_read), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        rv = 1'b0; rc = 2'b00; ra = '0;
        m_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (m_ready) stale++;
        end
        chk("stale_ready", 32'(stale), 32'd0);
        access(32'hffff0710, 1'b1, 4'b0000, 32'h0, 1'b0, 2);

        for (int n = 0; n < 200; n++) begin
            cat = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
            case (cat)
                0, 1, 2: a = a;
                3, 4:    a = 32'hffff0700 + a;
                5, 6:    a = 32'h00010000 + a;
                7:       a = 32'h40000000 | ($urandom & 32'h0fffffff);
                default: a = 32'h80000000 | $urandom;
            endcase
            wb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            access(a, 1'($urandom), wb, $urandom,
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
